// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//
// Truth-table stimulus and response checker for a two-input logic cell.
// The checker drives the cell inputs a/b through the four input vectors
// (a,b) = 00, 10, 01, 11. It holds each vector for a settle interval,
// samples the cell output y, and compares it against the expected table
// FUNC, indexed by {b,a}. Mismatches are counted with saturation at 15,
// and the first failing vector is remembered.
//
// Parameters
//   SETTLE  cycles a/b are held before the sample cycle (1..15, 0 acts as 1)
//   LOOPS   number of full four-vector passes per run (1..255)
//   FUNC    expected output table, bit index {b,a} (default NAND)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   begin a run, honoured only in IDLE and DONE
//   y         in   output of the cell under test
//   a, b      out  registered cell inputs
//   busy      out  high from DRIVE through the final SAMPLE
//   done      out  level, high while in DONE
//   pass      out  valid while done, 1 when no mismatch was seen
//   err_cnt   out  saturating mismatch count
//   fail_vec  out  {b,a} of the first mismatching vector
module gate_tt_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1,
    parameter logic [3:0]  FUNC   = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [1:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    // A settle interval of zero would never leave WAIT cleanly, so it is
    // promoted to one cycle.
    localparam logic [3:0] SETTLE_EFF = (SETTLE == 0) ? 4'd1 : 4'(SETTLE);
    localparam logic [8:0] LOOPS_W    = 9'(LOOPS);

    state_t     state;
    state_t     next_state;
    logic [1:0] vec;
    logic [7:0] loop;
    logic [3:0] cnt;

    logic mismatch;
    logic wrap;
    logic last_loop;

    assign mismatch  = (y != FUNC[vec]);
    assign wrap      = (vec == 2'd3);
    assign last_loop = (({1'b0, loop} + 9'd1) == LOOPS_W);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WAIT leaves on the edge where the settle counter
    // reads one, so WAIT lasts exactly SETTLE_EFF cycles. The final SAMPLE
    // of the last loop goes to DONE; every other SAMPLE returns to DRIVE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = DRIVE;
            DRIVE:  next_state = WAIT;
            WAIT:   if (cnt <= 4'd1) next_state = SAMPLE;
            SAMPLE: next_state = (wrap && last_loop) ? DONE : DRIVE;
            DONE:   if (start) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and datapath. Every output comes from a flop, so
    // there is no combinational path from y or start to any output. pass is
    // decided at the final sample edge from the post-update error count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 4'd0;
            fail_vec <= 2'd0;
            vec      <= 2'd0;
            loop     <= 8'd0;
            cnt      <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= 4'd0;
                        fail_vec <= 2'd0;
                        vec      <= 2'd0;
                        loop     <= 8'd0;
                    end
                end
                DRIVE: begin
                    a   <= vec[0];
                    b   <= vec[1];
                    cnt <= SETTLE_EFF;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_cnt != 4'd15) begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                        // A zero count means this is the first mismatch of the run.
                        if (err_cnt == 4'd0) begin
                            fail_vec <= vec;
                        end
                    end
                    vec <= vec + 2'd1;
                    if (wrap) begin
                        loop <= loop + 8'd1;
                        if (last_loop) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (!mismatch) && (err_cnt == 4'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Testbench for gate_tt_checker.
//
// Five checker instances with different parameter sets share one clock and
// reset. Each instance drives a behavioural cell model selected by a mode
// variable: 0 ideal NAND, 1 stuck-at-1, 2 stuck-at-0, 3 ideal AND.
// Edge numbers in the comments count from the start edge (edge 0). Outputs
// are sampled on the falling edge after the edge being checked.
module tb_gate_tt_checker;

    logic       clk;
    logic       rst_n;
    logic [4:0] startv;
    logic [1:0] mode_a, mode_b, mode_c, mode_d, mode_e;

    logic       y_a, a_a, b_a, busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [1:0] fv_a;
    logic       y_b, a_b, b_b, busy_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [1:0] fv_b;
    logic       y_c, a_c, b_c, busy_c, done_c, pass_c;
    logic [3:0] err_c;
    logic [1:0] fv_c;
    logic       y_d, a_d, b_d, busy_d, done_d, pass_d;
    logic [3:0] err_d;
    logic [1:0] fv_d;
    logic       y_e, a_e, b_e, busy_e, done_e, pass_e;
    logic [3:0] err_e;
    logic [1:0] fv_e;

    int checks;
    int failures;

    // Behavioural two-input cell selected by mode.
    function automatic logic cellModel(input logic [1:0] m, input logic ia, input logic ib);
        case (m)
            2'd0:    return ~(ia & ib);
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return ia & ib;
        endcase
    endfunction

    assign y_a = cellModel(mode_a, a_a, b_a);
    assign y_b = cellModel(mode_b, a_b, b_b);
    assign y_c = cellModel(mode_c, a_c, b_c);
    assign y_d = cellModel(mode_d, a_d, b_d);
    assign y_e = cellModel(mode_e, a_e, b_e);

    // Default NAND, one loop.
    gate_tt_checker #(.SETTLE(2), .LOOPS(1), .FUNC(4'b0111)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(startv[0]), .y(y_a), .a(a_a), .b(b_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fv_a));

    // Three loops.
    gate_tt_checker #(.SETTLE(2), .LOOPS(3), .FUNC(4'b0111)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(startv[1]), .y(y_b), .a(a_b), .b(b_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fv_b));

    // Five loops, shorter settle: vector period is 3 edges.
    gate_tt_checker #(.SETTLE(1), .LOOPS(5), .FUNC(4'b0111)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(startv[2]), .y(y_c), .a(a_c), .b(b_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .fail_vec(fv_c));

    // Six loops, enough mismatches to saturate the counter.
    gate_tt_checker #(.SETTLE(2), .LOOPS(6), .FUNC(4'b0111)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(startv[3]), .y(y_d), .a(a_d), .b(b_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .err_cnt(err_d), .fail_vec(fv_d));

    // AND truth table.
    gate_tt_checker #(.SETTLE(2), .LOOPS(1), .FUNC(4'b1000)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(startv[4]), .y(y_e), .a(a_e), .b(b_e),
        .busy(busy_e), .done(done_e), .pass(pass_e), .err_cnt(err_e), .fail_vec(fv_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse start for the selected instances across one rising edge (edge 0).
    // Returns on the falling edge after edge 0.
    task automatic applyStimulus(input logic [4:0] mask);
        startv = mask;
        @(negedge clk);
        startv = 5'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        startv   = 5'd0;
        mode_a   = 2'd0;
        mode_b   = 2'd1;
        mode_c   = 2'd2;
        mode_d   = 2'd2;
        mode_e   = 2'd3;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_a",     a_a,    0);
        checkOutput("rst_b",     b_a,    0);
        checkOutput("rst_busy",  busy_a, 0);
        checkOutput("rst_done",  done_a, 0);
        checkOutput("rst_pass",  pass_a, 0);
        checkOutput("rst_err",   err_a,  0);
        checkOutput("rst_fvec",  fv_a,   0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal NAND: sequence 00,10,01,11 on edges 1,5,9,13; done at edge 16.
        applyStimulus(5'b00001);
        checkOutput("t1_busy_rise", busy_a, 1);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            if (e % 4 == 1) checkOutput("t1_vec", {30'd0, b_a, a_a}, (e - 1) / 4);
            if (e == 15) checkOutput("t1_done_early", done_a, 0);
        end
        checkOutput("t1_done", done_a, 1);
        checkOutput("t1_pass", pass_a, 1);
        checkOutput("t1_err",  err_a,  0);
        checkOutput("t1_fvec", fv_a,   0);
        checkOutput("t1_busy_fall", busy_a, 0);

        // Stuck-at-1, three loops: only vector 3 fails; done at edge 48.
        applyStimulus(5'b00010);
        repeat (16) @(negedge clk);
        checkOutput("t2_err_first",  err_b, 1);
        checkOutput("t2_fvec_first", fv_b,  3);
        repeat (31) @(negedge clk);
        checkOutput("t2_done_early", done_b, 0);
        @(negedge clk);
        checkOutput("t2_done", done_b, 1);
        checkOutput("t2_err",  err_b,  3);
        checkOutput("t2_fvec", fv_b,   3);
        checkOutput("t2_pass", pass_b, 0);

        // Stuck-at-0: C has five loops with period 3 (done at edge 60), and
        // D has six loops with period 4 (done at edge 96, counter saturates).
        applyStimulus(5'b01100);
        repeat (3) @(negedge clk);
        checkOutput("t3_c_err_first", err_c, 1);
        checkOutput("t3_c_fvec_first", fv_c, 0);
        repeat (56) @(negedge clk);
        checkOutput("t3_c_done_early", done_c, 0);
        @(negedge clk);
        checkOutput("t3_c_done", done_c, 1);
        checkOutput("t3_c_err",  err_c,  15);
        checkOutput("t3_c_fvec", fv_c,   0);
        checkOutput("t3_c_pass", pass_c, 0);
        repeat (35) @(negedge clk);
        checkOutput("t3_d_done_early", done_d, 0);
        @(negedge clk);
        checkOutput("t3_d_done", done_d, 1);
        checkOutput("t3_d_err",  err_d,  15);
        checkOutput("t3_d_fvec", fv_d,   0);

        // AND table with an AND cell passes; the same run with a NAND cell
        // mismatches on every vector.
        applyStimulus(5'b10000);
        repeat (16) @(negedge clk);
        checkOutput("t4_and_done", done_e, 1);
        checkOutput("t4_and_pass", pass_e, 1);
        checkOutput("t4_and_err",  err_e,  0);
        mode_e = 2'd0;
        applyStimulus(5'b10000);
        checkOutput("t4_restart_done", done_e, 0);
        repeat (16) @(negedge clk);
        checkOutput("t4_nand_done", done_e, 1);
        checkOutput("t4_nand_pass", pass_e, 0);
        checkOutput("t4_nand_err",  err_e,  4);
        checkOutput("t4_nand_fvec", fv_e,   0);

        // Reset during WAIT of vector 2 (driven at edge 9, reset at edge 10).
        mode_a = 2'd2;
        applyStimulus(5'b00001);
        repeat (9) @(negedge clk);
        checkOutput("t5_vec2", {30'd0, b_a, a_a}, 2);
        checkOutput("t5_err_pre", err_a, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5_a",    a_a,    0);
        checkOutput("t5_b",    b_a,    0);
        checkOutput("t5_busy", busy_a, 0);
        checkOutput("t5_done", done_a, 0);
        checkOutput("t5_err",  err_a,  0);
        mode_a = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("t5_idle_busy", busy_a, 0);
        applyStimulus(5'b00001);
        repeat (16) @(negedge clk);
        checkOutput("t5_rerun_done", done_a, 1);
        checkOutput("t5_rerun_pass", pass_a, 1);
        checkOutput("t5_rerun_err",  err_a,  0);

        // start held high: ignored mid-run, restarts from DONE at edge 17.
        mode_a = 2'd1;
        startv = 5'b00001;
        @(negedge clk);
        repeat (9) @(negedge clk);
        checkOutput("t6_vec2", {30'd0, b_a, a_a}, 2);
        checkOutput("t6_busy", busy_a, 1);
        repeat (7) @(negedge clk);
        checkOutput("t6_done", done_a, 1);
        checkOutput("t6_err",  err_a,  1);
        checkOutput("t6_fvec", fv_a,   3);
        checkOutput("t6_pass", pass_a, 0);
        @(negedge clk);
        checkOutput("t6_restart_done", done_a, 0);
        checkOutput("t6_restart_err",  err_a,  0);
        checkOutput("t6_restart_fvec", fv_a,   0);
        checkOutput("t6_restart_busy", busy_a, 1);
        @(negedge clk);
        checkOutput("t6_restart_vec0", {30'd0, b_a, a_a}, 0);
        startv = 5'd0;
        repeat (15) @(negedge clk);
        checkOutput("t6_second_done", done_a, 1);
        checkOutput("t6_second_err",  err_a,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
